// File: rtl/tick_monitor.sv
// tick_monitor: measures clkin cycles between rising edges of tick_in, checks
// each interval against EXP_PERIOD +/- TOL, tracks lock and flags a missing tick.
// Define TICK_MONITOR_STICKY_TIMEOUT_EN for a timeout flag held until rst;
// otherwise timeout is a one-cycle pulse.
module tick_monitor #(
  parameter int unsigned      N_BIT      = 16,
  parameter logic [N_BIT-1:0] EXP_PERIOD = 16'd50001,
  parameter logic [N_BIT-1:0] TOL        = 16'd0,
  parameter int unsigned      LOCK_N     = 4
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             enable,
  input  logic             tick_in,
  output logic [N_BIT-1:0] period,
  output logic             period_valid,
  output logic             in_range,
  output logic             timeout,
  output logic             locked
);

  localparam int unsigned LW = $clog2(LOCK_N + 1);
  localparam logic [N_BIT:0] HI = {1'b0, EXP_PERIOD} + {1'b0, TOL};
  localparam logic [N_BIT:0] LO = (EXP_PERIOD >= TOL) ? ({1'b0, EXP_PERIOD} - {1'b0, TOL}) : '0;
  localparam logic [LW-1:0] LOCK_MAX = LW'(LOCK_N);

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } state_e;

  state_e           state_q, state_d;
  logic             prev_q, prev_d;
  logic [N_BIT-1:0] cnt_q, cnt_d;
  logic [N_BIT-1:0] period_q, period_d;
  logic             period_valid_q, period_valid_d;
  logic             in_range_q, in_range_d;
  logic             timeout_q, timeout_d;
  logic             locked_q, locked_d;
  logic [LW-1:0]    lock_q, lock_d;

  logic             tick_edge;
  logic [N_BIT:0]   cnt_ext;
  logic             cnt_in_win;

  assign tick_edge  = tick_in & ~prev_q;
  assign cnt_ext    = {1'b0, cnt_q};
  assign cnt_in_win = (cnt_ext >= LO) && (cnt_ext <= HI);

  always_ff @(posedge clkin) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      prev_q         <= 1'b0;
      cnt_q          <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      in_range_q     <= 1'b0;
      timeout_q      <= 1'b0;
      locked_q       <= 1'b0;
      lock_q         <= '0;
    end else begin
      state_q        <= state_d;
      prev_q         <= prev_d;
      cnt_q          <= cnt_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      in_range_q     <= in_range_d;
      timeout_q      <= timeout_d;
      locked_q       <= locked_d;
      lock_q         <= lock_d;
    end
  end

  // Edge priority over timeout: an edge landing exactly on cnt == HI is a valid period.
  always_comb begin
    state_d        = state_q;
    prev_d         = tick_in;
    cnt_d          = cnt_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    in_range_d     = in_range_q;
    locked_d       = locked_q;
    lock_d         = lock_q;
`ifdef TICK_MONITOR_STICKY_TIMEOUT_EN
    timeout_d      = timeout_q;
`else
    timeout_d      = 1'b0;
`endif

    if (enable) begin
      unique case (state_q)
        ST_IDLE: begin
          if (tick_edge) begin
            cnt_d   = {{(N_BIT-1){1'b0}}, 1'b1};
            state_d = ST_MEASURE;
          end
        end
        ST_MEASURE: begin
          if (tick_edge) begin
            period_d       = cnt_q;
            period_valid_d = 1'b1;
            cnt_d          = {{(N_BIT-1){1'b0}}, 1'b1};
            in_range_d     = cnt_in_win;
            if (cnt_in_win) begin
              lock_d = (lock_q == LOCK_MAX) ? lock_q : lock_q + 1'b1;
            end else begin
              lock_d = '0;
            end
            locked_d = (lock_d == LOCK_MAX);
          end else if (cnt_ext == HI) begin
            timeout_d = 1'b1;
            lock_d    = '0;
            locked_d  = 1'b0;
            cnt_d     = '0;
            state_d   = ST_IDLE;
          end else begin
            cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign in_range     = in_range_q;
  assign timeout      = timeout_q;
  assign locked       = locked_q;

endmodule

// File: tb/tb_tick_monitor.sv
// Directed bench for tick_monitor with N_BIT=8, EXP_PERIOD=10, TOL=1, LOCK_N=3
// (window 9..11). Inputs change 1 ns after a rising edge; outputs are sampled there.
module tb_tick_monitor;

  logic       clkin = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       tick_in = 1'b0;
  logic [7:0] period;
  logic       period_valid;
  logic       in_range;
  logic       timeout;
  logic       locked;

  int checks = 0;
  int errors = 0;

  tick_monitor #(
    .N_BIT(8),
    .EXP_PERIOD(8'd10),
    .TOL(8'd1),
    .LOCK_N(3)
  ) dut (
    .clkin(clkin),
    .rst(rst),
    .enable(enable),
    .tick_in(tick_in),
    .period(period),
    .period_valid(period_valid),
    .in_range(in_range),
    .timeout(timeout),
    .locked(locked)
  );

  always #5 clkin = ~clkin;

  task automatic cyc();
    @(posedge clkin);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cyc();
  endtask

  // One-cycle tick sampled at the next rising edge.
  task automatic pulse();
    tick_in = 1'b1;
    cyc();
    tick_in = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_period"}, 32'(period), 32'd0);
    check({tag, "_pv"}, 32'(period_valid), 32'd0);
    check({tag, "_in_range"}, 32'(in_range), 32'd0);
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
  endtask

  logic sticky_exp;

  initial begin
`ifdef TICK_MONITOR_STICKY_TIMEOUT_EN
    sticky_exp = 1'b1;
`else
    sticky_exp = 1'b0;
`endif
    // Reset with random tick activity
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_in = 1'($urandom_range(0, 1));
      cyc();
    end
    check_all_zero("reset");
    rst = 1'b0;
    tick_in = 1'b0;
    cyc();

    // First edge only arms the measurement
    pulse();
    check("first_edge_pv", 32'(period_valid), 32'd0);

    // Three periods of 10 -> lock on the third
    for (int i = 1; i <= 3; i++) begin
      cyc();
      check("lock_pv_drop", 32'(period_valid), 32'd0);
      idle(8);
      pulse();
      check("lock_pv", 32'(period_valid), 32'd1);
      check("lock_period", 32'(period), 32'd10);
      check("lock_in_range", 32'(in_range), 32'd1);
      check("lock_locked", 32'(locked), (i == 3) ? 32'd1 : 32'd0);
    end

    // Short period (8) while locked -> out of range, lock lost
    idle(7);
    pulse();
    check("short_period", 32'(period), 32'd8);
    check("short_in_range", 32'(in_range), 32'd0);
    check("short_locked", 32'(locked), 32'd0);

    // Lower bound 9
    idle(8);
    pulse();
    check("lo_period", 32'(period), 32'd9);
    check("lo_in_range", 32'(in_range), 32'd1);
    check("lo_locked", 32'(locked), 32'd0);

    // Upper bound 11: edge wins over timeout
    idle(10);
    pulse();
    check("hi_pv", 32'(period_valid), 32'd1);
    check("hi_period", 32'(period), 32'd11);
    check("hi_in_range", 32'(in_range), 32'd1);
    check("hi_timeout", 32'(timeout), 32'd0);
    check("hi_locked", 32'(locked), 32'd0);

    // Third consecutive good period relocks
    idle(9);
    pulse();
    check("relock_period", 32'(period), 32'd10);
    check("relock_locked", 32'(locked), 32'd1);

    // Timeout: last edge at k, flag after posedge k+11
    idle(10);
    check("to_before", 32'(timeout), 32'd0);
    cyc();
    check("to_fire", 32'(timeout), 32'd1);
    check("to_locked", 32'(locked), 32'd0);
    check("to_pv", 32'(period_valid), 32'd0);
    cyc();
    check("to_after", 32'(timeout), 32'(sticky_exp));
    pulse();
    check("to_rearm_pv", 32'(period_valid), 32'd0);
    idle(9);
    pulse();
    check("to_next_pv", 32'(period_valid), 32'd1);
    check("to_next_period", 32'(period), 32'd10);
    check("to_next_locked", 32'(locked), 32'd0);

    // Enable low for 5 of 15 cycles -> 10 counted
    idle(2);
    enable = 1'b0;
    idle(5);
    check("gap_pv", 32'(period_valid), 32'd0);
    check("gap_period_held", 32'(period), 32'd10);
    enable = 1'b1;
    idle(7);
    pulse();
    check("gap_pv_out", 32'(period_valid), 32'd1);
    check("gap_period", 32'(period), 32'd10);
    check("gap_in_range", 32'(in_range), 32'd1);
    check("gap_locked", 32'(locked), 32'd0);

    // Tick held high 4 cycles counts once
    idle(9);
    tick_in = 1'b1;
    cyc();
    check("held_pv", 32'(period_valid), 32'd1);
    check("held_period", 32'(period), 32'd10);
    check("held_locked", 32'(locked), 32'd1);
    cyc();
    check("held_no_second", 32'(period_valid), 32'd0);
    idle(2);
    tick_in = 1'b0;
    idle(6);
    pulse();
    check("held_next_pv", 32'(period_valid), 32'd1);
    check("held_next_period", 32'(period), 32'd10);
    check("held_next_locked", 32'(locked), 32'd1);

    // Reset mid-measurement
    idle(5);
    rst = 1'b1;
    cyc();
    check_all_zero("midrst");
    rst = 1'b0;
    cyc();
    pulse();
    check("midrst_rearm_pv", 32'(period_valid), 32'd0);
    idle(9);
    pulse();
    check("midrst_pv", 32'(period_valid), 32'd1);
    check("midrst_period", 32'(period), 32'd10);
    check("midrst_in_range", 32'(in_range), 32'd1);
    check("midrst_locked", 32'(locked), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
